// File: rtl/chan_mux_demux_router.sv
`default_nettype none
// ============================================================================
// Module   : chan_mux_demux_router
// Purpose  : Registered N_IN -> N_OUT channel router. One source channel is
//            copied to one destination channel each cycle; all other
//            destinations are held at zero. Route changes are requested over
//            a valid/ready handshake and are separated by GUARD blanking
//            cycles, so no destination ever sees a partial or mixed sample.
// Ports    : clk, rst_n          clock / async active-low reset
//            in_data             packed inputs, ch k = in_data[k*WIDTH +: WIDTH]
//            req_in_sel/out_sel  requested route, qualified by req_valid
//            req_ready           high while routing (request can be taken)
//            out_data            packed outputs, only the active dest is non-zero
//            out_active          one-hot active destination, 0 while blanking
//            cur_in_sel/out_sel  current route
//            busy                high during the blanking interval
//            req_err             one-cycle pulse on an out-of-range request
// Revision : 1.0  initial release
// ============================================================================
module chan_mux_demux_router #(
    parameter int WIDTH = 1,
    parameter int N_IN  = 2,
    parameter int N_OUT = 4,
    parameter int GUARD = 2,
    localparam int SI   = $clog2(N_IN),
    localparam int SO   = $clog2(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_IN*WIDTH-1:0]  in_data,
    input  logic [SI-1:0]          req_in_sel,
    input  logic [SO-1:0]          req_out_sel,
    input  logic                   req_valid,
    output logic                   req_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]       out_active,
    output logic [SI-1:0]          cur_in_sel,
    output logic [SO-1:0]          cur_out_sel,
    output logic                   busy,
    output logic                   req_err
);

    localparam int CW = (GUARD > 1) ? $clog2(GUARD) : 1;

    typedef enum logic [0:0] {
        ST_ROUTE = 1'b0,
        ST_GUARD = 1'b1
    } state_t;

    state_t                 state_q,       state_d;
    logic [CW-1:0]          guard_cnt_q,   guard_cnt_d;
    logic [SI-1:0]          cur_in_q,      cur_in_d;
    logic [SO-1:0]          cur_out_q,     cur_out_d;
    logic [SI-1:0]          pend_in_q,     pend_in_d;
    logic [SO-1:0]          pend_out_q,    pend_out_d;
    logic [N_OUT*WIDTH-1:0] out_data_q,    out_data_d;
    logic [N_OUT-1:0]       out_active_q,  out_active_d;
    logic                   busy_q,        busy_d;
    logic                   req_err_d,     req_err_q;

    // Route used to build next-cycle outputs; route_en low blanks everything.
    logic                   route_en;
    logic [SI-1:0]          rt_in;
    logic [SO-1:0]          rt_out;
    logic [WIDTH-1:0]       src;
    logic                   req_bad;

    // Zero-extended compare so non-power-of-2 channel counts flag only the
    // encodings at or above the channel count.
    assign req_bad = ({{(32-SI){1'b0}}, req_in_sel}  >= 32'(N_IN)) ||
                     ({{(32-SO){1'b0}}, req_out_sel} >= 32'(N_OUT));

    always_comb begin
        state_d     = state_q;
        guard_cnt_d = guard_cnt_q;
        cur_in_d    = cur_in_q;
        cur_out_d   = cur_out_q;
        pend_in_d   = pend_in_q;
        pend_out_d  = pend_out_q;
        busy_d      = 1'b0;
        req_err_d   = 1'b0;
        route_en    = 1'b1;
        rt_in       = cur_in_q;
        rt_out      = cur_out_q;

        case (state_q)
            ST_ROUTE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        req_err_d = 1'b1;
                    end else if ((req_in_sel != cur_in_q) || (req_out_sel != cur_out_q)) begin
                        // Blank already in the acceptance cycle so the zero
                        // window on the outputs lines up with busy.
                        pend_in_d   = req_in_sel;
                        pend_out_d  = req_out_sel;
                        guard_cnt_d = CW'(GUARD - 1);
                        state_d     = ST_GUARD;
                        busy_d      = 1'b1;
                        route_en    = 1'b0;
                    end
                end
            end
            ST_GUARD: begin
                busy_d   = 1'b1;
                route_en = 1'b0;
                if (guard_cnt_q == '0) begin
                    // Last blank cycle: commit the new route and drive its
                    // data so it appears on the first ROUTE cycle.
                    state_d   = ST_ROUTE;
                    cur_in_d  = pend_in_q;
                    cur_out_d = pend_out_q;
                    busy_d    = 1'b0;
                    route_en  = 1'b1;
                    rt_in     = pend_in_q;
                    rt_out    = pend_out_q;
                end else begin
                    guard_cnt_d = guard_cnt_q - CW'(1);
                end
            end
            default: state_d = ST_ROUTE;
        endcase

        src = '0;
        for (int j = 0; j < N_IN; j++) begin
            if (SI'(j) == rt_in) begin
                src = in_data[j*WIDTH +: WIDTH];
            end
        end

        out_data_d   = '0;
        out_active_d = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (route_en && (SO'(k) == rt_out)) begin
                out_data_d[k*WIDTH +: WIDTH] = src;
                out_active_d[k]              = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ROUTE;
            guard_cnt_q  <= '0;
            cur_in_q     <= '0;
            cur_out_q    <= '0;
            pend_in_q    <= '0;
            pend_out_q   <= '0;
            out_data_q   <= '0;
            out_active_q <= '0;
            busy_q       <= 1'b0;
            req_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            guard_cnt_q  <= guard_cnt_d;
            cur_in_q     <= cur_in_d;
            cur_out_q    <= cur_out_d;
            pend_in_q    <= pend_in_d;
            pend_out_q   <= pend_out_d;
            out_data_q   <= out_data_d;
            out_active_q <= out_active_d;
            busy_q       <= busy_d;
            req_err_q    <= req_err_d;
        end
    end

    assign req_ready   = (state_q == ST_ROUTE);
    assign out_data    = out_data_q;
    assign out_active  = out_active_q;
    assign cur_in_sel  = cur_in_q;
    assign cur_out_sel = cur_out_q;
    assign busy        = busy_q;
    assign req_err     = req_err_q;

endmodule
`default_nettype wire

// File: tb/tb_chan_mux_demux_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_chan_mux_demux_router
// Purpose  : Directed self-checking bench for chan_mux_demux_router.
//            u_dut  : WIDTH=1, N_IN=2, N_OUT=4, GUARD=2
//            u_dut3 : WIDTH=1, N_IN=3, N_OUT=4, GUARD=2 (non-power-of-2 range)
// Revision : 1.0  initial release
// ============================================================================
module tb_chan_mux_demux_router;

    logic       clk;
    logic       rst_n;

    logic [1:0] in_data;
    logic [0:0] req_in_sel;
    logic [1:0] req_out_sel;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] out_data;
    logic [3:0] out_active;
    logic [0:0] cur_in_sel;
    logic [1:0] cur_out_sel;
    logic       busy;
    logic       req_err;

    logic [2:0] in3;
    logic [1:0] req_in3;
    logic [1:0] req_out3;
    logic       req_valid3;
    logic       req_ready3;
    logic [3:0] out3;
    logic [3:0] act3;
    logic [1:0] cur_in3;
    logic [1:0] cur_out3;
    logic       busy3;
    logic       req_err3;

    int n_vec = 0;
    int n_err = 0;

    chan_mux_demux_router #(.WIDTH(1), .N_IN(2), .N_OUT(4), .GUARD(2)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .req_in_sel  (req_in_sel),
        .req_out_sel (req_out_sel),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .out_data    (out_data),
        .out_active  (out_active),
        .cur_in_sel  (cur_in_sel),
        .cur_out_sel (cur_out_sel),
        .busy        (busy),
        .req_err     (req_err)
    );

    chan_mux_demux_router #(.WIDTH(1), .N_IN(3), .N_OUT(4), .GUARD(2)) u_dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in3),
        .req_in_sel  (req_in3),
        .req_out_sel (req_out3),
        .req_valid   (req_valid3),
        .req_ready   (req_ready3),
        .out_data    (out3),
        .out_active  (act3),
        .cur_in_sel  (cur_in3),
        .cur_out_sel (cur_out3),
        .busy        (busy3),
        .req_err     (req_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        in_data     = '0;
        req_in_sel  = '0;
        req_out_sel = '0;
        req_valid   = 1'b0;
        in3         = '0;
        req_in3     = '0;
        req_out3    = '0;
        req_valid3  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_data",   32'(out_data),    32'h0);
        chk("rst_out_active", 32'(out_active),  32'h0);
        chk("rst_busy",       32'(busy),        32'h0);
        chk("rst_req_err",    32'(req_err),     32'h0);
        chk("rst_req_ready",  32'(req_ready),   32'h1);
        chk("rst_cur_in",     32'(cur_in_sel),  32'h0);
        chk("rst_cur_out",    32'(cur_out_sel), 32'h0);

        // Release reset; dut3 sees an out-of-range source request at once.
        rst_n      = 1'b1;
        in_data    = 2'b01;
        in3        = 3'b001;
        req_in3    = 2'd3;
        req_out3   = 2'd1;
        req_valid3 = 1'b1;
        tick();
        chk("first_out_data",   32'(out_data),   32'h1);
        chk("first_out_active", 32'(out_active), 32'h1);
        chk("first_req_ready",  32'(req_ready),  32'h1);
        chk("first_busy",       32'(busy),       32'h0);
        chk("oor_req_err",      32'(req_err3),   32'h1);
        chk("oor_busy",         32'(busy3),      32'h0);
        chk("oor_cur_in",       32'(cur_in3),    32'h0);
        chk("oor_out",          32'(out3),       32'h1);

        req_valid3 = 1'b0;
        in_data    = 2'b10;
        in3        = 3'b100;
        tick();
        chk("ch0_low_out",    32'(out_data),   32'h0);
        chk("ch0_low_active", 32'(out_active), 32'h1);
        chk("oor_err_pulse",  32'(req_err3),   32'h0);
        chk("oor_out2",       32'(out3),       32'h0);

        // Highest legal source on the 3-input router is accepted normally.
        req_in3    = 2'd2;
        req_out3   = 2'd1;
        req_valid3 = 1'b1;
        tick();
        chk("in2_busy",  32'(busy3),      32'h1);
        chk("in2_err",   32'(req_err3),   32'h0);
        chk("in2_ready", 32'(req_ready3), 32'h0);
        req_valid3 = 1'b0;
        tick();
        tick();
        chk("in2_cur_in",  32'(cur_in3),  32'h2);
        chk("in2_cur_out", 32'(cur_out3), 32'h1);
        chk("in2_out",     32'(out3),     32'h2);
        chk("in2_busy_end",32'(busy3),    32'h0);

        // Route change 0->0 to 1->2 with a two-cycle blank window.
        in_data     = 2'b11;
        req_in_sel  = 1'd1;
        req_out_sel = 2'd2;
        req_valid   = 1'b1;
        tick();
        chk("g1_busy",   32'(busy),       32'h1);
        chk("g1_out",    32'(out_data),   32'h0);
        chk("g1_active", 32'(out_active), 32'h0);
        chk("g1_ready",  32'(req_ready),  32'h0);
        req_valid = 1'b0;
        tick();
        chk("g2_busy",   32'(busy),       32'h1);
        chk("g2_out",    32'(out_data),   32'h0);
        chk("g2_active", 32'(out_active), 32'h0);
        in_data = 2'b10;
        tick();
        chk("new_busy",    32'(busy),        32'h0);
        chk("new_cur_in",  32'(cur_in_sel),  32'h1);
        chk("new_cur_out", 32'(cur_out_sel), 32'h2);
        chk("new_out",     32'(out_data),    32'h4);
        chk("new_active",  32'(out_active),  32'h4);
        in_data = 2'b01;
        tick();
        chk("lag_out_lo",  32'(out_data),   32'h0);
        chk("lag_active",  32'(out_active), 32'h4);
        in_data = 2'b10;
        tick();
        chk("lag_out_hi",  32'(out_data),   32'h4);

        // Same pair: no blanking, no error.
        req_in_sel  = 1'd1;
        req_out_sel = 2'd2;
        req_valid   = 1'b1;
        tick();
        chk("same_busy",  32'(busy),      32'h0);
        chk("same_err",   32'(req_err),   32'h0);
        chk("same_out",   32'(out_data),  32'h4);
        chk("same_ready", 32'(req_ready), 32'h1);

        // Switch to 0->3, then hold a different pair 1->1 through the guard.
        req_in_sel  = 1'd0;
        req_out_sel = 2'd3;
        in_data     = 2'b01;
        tick();
        chk("b2b_g1_busy",  32'(busy),      32'h1);
        chk("b2b_g1_ready", 32'(req_ready), 32'h0);
        req_in_sel  = 1'd1;
        req_out_sel = 2'd1;
        tick();
        chk("b2b_g2_busy",  32'(busy),      32'h1);
        chk("b2b_g2_ready", 32'(req_ready), 32'h0);
        tick();
        chk("b2b_rt_ready",   32'(req_ready),   32'h1);
        chk("b2b_rt_cur_in",  32'(cur_in_sel),  32'h0);
        chk("b2b_rt_cur_out", 32'(cur_out_sel), 32'h3);
        chk("b2b_rt_out",     32'(out_data),    32'h8);
        tick();
        chk("b2b_2nd_busy",   32'(busy),        32'h1);
        chk("b2b_2nd_out",    32'(out_data),    32'h0);
        chk("b2b_2nd_cur",    32'(cur_out_sel), 32'h3);
        req_valid = 1'b0;
        tick();
        chk("b2b_2nd_g2",     32'(busy),        32'h1);

        // Reset in the second guard cycle discards the pending 1->1 route.
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out",    32'(out_data),    32'h0);
        chk("mid_rst_active", 32'(out_active),  32'h0);
        chk("mid_rst_busy",   32'(busy),        32'h0);
        chk("mid_rst_cur_in", 32'(cur_in_sel),  32'h0);
        chk("mid_rst_cur_out",32'(cur_out_sel), 32'h0);
        chk("mid_rst_ready",  32'(req_ready),   32'h1);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        in_data = 2'b01;
        tick();
        chk("post_rst_out",     32'(out_data),    32'h1);
        chk("post_rst_cur_in",  32'(cur_in_sel),  32'h0);
        chk("post_rst_cur_out", 32'(cur_out_sel), 32'h0);
        tick();
        chk("post_rst_busy",    32'(busy),        32'h0);
        chk("post_rst_active",  32'(out_active),  32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chan_mux_demux_router.md
Name: chan_mux_demux_router

Overview:
- Parametrised, registered successor to the 2:1 mux / 1:4 demux pair.
- Routes one of N_IN input channels of WIDTH bits to one of N_OUT output channels.
- Route changes use a valid/ready handshake with a guard (blanking) interval, so a destination never sees a partial or mixed sample during a switch.
- Sits between clock/stream sources and downstream consumers; all outputs are registered.

Parameters:
- WIDTH, 1, bits per channel.
- N_IN, 2, number of input channels (>=2).
- N_OUT, 4, number of output channels (>=2).
- GUARD, 2, blanking cycles inserted on a route change (>=1).
- SI, $clog2(N_IN), input select width (localparam).
- SO, $clog2(N_OUT), output select width (localparam).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  N_IN*WIDTH  packed inputs; channel k = in_data[k*WIDTH +: WIDTH].
- req_in_sel  in  SI  requested source channel.
- req_out_sel  in  SO  requested destination channel.
- req_valid  in  1  route-change request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- out_data  out  N_OUT*WIDTH  packed outputs; unselected channels are 0.
- out_active  out  N_OUT  one-hot: the destination currently carrying data; 0 during guard.
- cur_in_sel  out  SI  active source.
- cur_out_sel  out  SO  active destination.
- busy  out  1  high while in GUARD state.
- req_err  out  1  one-cycle pulse on an accepted out-of-range request.

Behaviour:
Reset (async assert, sync deassert):
- state=ROUTE; cur_in_sel=0; cur_out_sel=0.
- out_data=0; out_active=0; busy=0; req_err=0; guard counter=0.
- First data appears the cycle after reset release.

ROUTE:
- Each cycle: out_data[cur_out_sel] <= in_data[cur_in_sel]; all other channels <= 0; out_active <= one-hot(cur_out_sel).
- Latency is one clock from in_data to out_data.
- req_ready=1 only in ROUTE.

Request handling on handshake (req_valid && req_ready):
- req_in_sel >= N_IN or req_out_sel >= N_OUT: request dropped; req_err=1 for one cycle; route unchanged; stay in ROUTE.
- Same pair as current: no-op; stay in ROUTE; data uninterrupted.
- Otherwise: latch the pending pair; go to GUARD next cycle; counter <= GUARD-1.

GUARD:
- out_data=0; out_active=0; busy=1; req_ready=0.
- req_valid is ignored and the requester must hold it.
- Counter decrements each cycle. When it reaches 0: cur_in_sel/cur_out_sel <= pending; state <= ROUTE.
- New-route data appears on the first ROUTE cycle after GUARD.
- Blank window is exactly GUARD cycles; total request-to-new-data latency is GUARD+1 cycles after acceptance.

Boundaries:
- Reset asserted mid-GUARD: pending pair is discarded; return to the reset route.
- A new request in the first ROUTE cycle after GUARD is accepted normally, giving back-to-back switches.
- Non-power-of-2 N_IN/N_OUT: only encodings >= N are out of range.
- in_data is sampled combinationally, and a change is reflected the next cycle.

Test Plan:
- Reset, then drive in_data channel0=1 (WIDTH=1, N_IN=2, N_OUT=4) -> one cycle later out_data=4'b0001, out_active=4'b0001, req_ready=1.
- Request in=1, out=2 with two clocks (ch0 period 1000 units, ch1 period 250 units) -> out_data/out_active=0 and busy=1 for exactly 2 cycles; then out_data[2] follows ch1 with 1-cycle lag; cur_in_sel=1, cur_out_sel=2.
- Request equal to the current pair -> no busy, no blanking, req_err=0.
- Out-of-range request with N_IN=3 and req_in_sel=3 -> req_err pulses one cycle; route unchanged.
- Hold req_valid with a different pair during GUARD -> req_ready=0 throughout, and the request is accepted on the first ROUTE cycle; verify a second GUARD window follows.
- Assert rst_n low during the second GUARD cycle -> outputs 0 immediately; after release, route is 0->0 and the pending pair is lost.
